tail_light_ctrl: RTL

Turn/hazard/brake scheduler for the rear lamp cluster. It latches the driver's left and right turn requests, shares the six lamps between them with round-robin fairness, and sequences a 3-step sweep per request. Hazard overrides everything, and brake lighting fills any lamps not currently sweeping. It sits between the stalk/switch inputs and the lamp drivers, and contains its own tick prescaler so the sequence steps at a human-visible rate from the board clock.

---
 rtl/tail_light_ctrl.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/tail_light_ctrl.sv
// Rear lamp turn/hazard/brake sequencer with built-in tick prescaler.
// Optional brake fill enabled by defining TAIL_BRAKE_EN.
module tail_light_ctrl #(
   parameter int unsigned DIV = 50_000_000
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       LEFT,
   input  logic       RIGHT,
   input  logic       HAZ,
`ifdef TAIL_BRAKE_EN
   input  logic       BRAKE,
`endif
   output logic       LA,
   output logic       LB,
   output logic       LC,
   output logic       RA,
   output logic       RB,
   output logic       RC,
   output logic       BUSY,
   output logic [3:0] STATE
);

   localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

   typedef enum logic [3:0] {
      S_IDLE = 4'd0,
      S_L1   = 4'd1,
      S_L2   = 4'd2,
      S_L3   = 4'd3,
      S_R1   = 4'd4,
      S_R2   = 4'd5,
      S_R3   = 4'd6,
      S_HON  = 4'd7,
      S_HOFF = 4'd8
   } state_t;

   logic [CW-1:0] cnt_q, cnt_d;
   logic          tick;
   state_t        state_q, state_d;
   logic          pend_l_q, pend_l_d;
   logic          pend_r_q, pend_r_d;
   logic          last_r_q, last_r_d;
   logic          clr_l, clr_r;
   logic [5:0]    lamps_q, lamps_d;
   logic          busy_q, busy_d;
   logic [3:0]    state_out_q, state_out_d;
   logic          brake;

`ifdef TAIL_BRAKE_EN
   assign brake = BRAKE;
`else
   assign brake = 1'b0;
`endif

   // Prescaler: one-cycle tick at the top of each DIV-cycle period.
   always_comb begin
      tick  = (cnt_q == CW'(DIV - 1));
      cnt_d = tick ? '0 : cnt_q + CW'(1);
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         cnt_q       <= '0;
         state_q     <= S_IDLE;
         pend_l_q    <= 1'b0;
         pend_r_q    <= 1'b0;
         last_r_q    <= 1'b1;
         lamps_q     <= '0;
         busy_q      <= 1'b0;
         state_out_q <= 4'(S_IDLE);
      end else begin
         cnt_q       <= cnt_d;
         state_q     <= state_d;
         pend_l_q    <= pend_l_d;
         pend_r_q    <= pend_r_d;
         last_r_q    <= last_r_d;
         lamps_q     <= lamps_d;
         busy_q      <= busy_d;
         state_out_q <= state_out_d;
      end
   end

   // Next state; pending bits clear on service but a same-cycle request keeps them set.
   always_comb begin
      state_d  = state_q;
      last_r_d = last_r_q;
      clr_l    = 1'b0;
      clr_r    = 1'b0;
      if (tick) begin
         if (HAZ) begin
            state_d = (state_q == S_HON) ? S_HOFF : S_HON;
            clr_l   = 1'b1;
            clr_r   = 1'b1;
         end else begin
            case (state_q)
               S_HON, S_HOFF: state_d = S_IDLE;
               S_L1:          state_d = S_L2;
               S_L2:          state_d = S_L3;
               S_R1:          state_d = S_R2;
               S_R2:          state_d = S_R3;
               default: begin
                  if (pend_l_q && (!pend_r_q || last_r_q)) begin
                     state_d  = S_L1;
                     clr_l    = 1'b1;
                     last_r_d = 1'b0;
                  end else if (pend_r_q) begin
                     state_d  = S_R1;
                     clr_r    = 1'b1;
                     last_r_d = 1'b1;
                  end else begin
                     state_d  = S_IDLE;
                  end
               end
            endcase
         end
      end
      pend_l_d = LEFT  | (pend_l_q & ~clr_l);
      pend_r_d = RIGHT | (pend_r_q & ~clr_r);
   end

   // Lamp pattern from current state; brake fills whichever side is not sweeping.
   always_comb begin
      lamps_d     = 6'b000_000;
      busy_d      = (state_q != S_IDLE);
      state_out_d = 4'(state_q);
      case (state_q)
         S_L1:    lamps_d = 6'b100_000;
         S_L2:    lamps_d = 6'b110_000;
         S_L3:    lamps_d = 6'b111_000;
         S_R1:    lamps_d = 6'b000_100;
         S_R2:    lamps_d = 6'b000_110;
         S_R3:    lamps_d = 6'b000_111;
         S_HON:   lamps_d = 6'b111_111;
         default: lamps_d = 6'b000_000;
      endcase
      if (brake) begin
         case (state_q)
            S_IDLE:             lamps_d = 6'b111_111;
            S_L1, S_L2, S_L3:   lamps_d[2:0] = 3'b111;
            S_R1, S_R2, S_R3:   lamps_d[5:3] = 3'b111;
            default:            ;
         endcase
      end
   end

   assign {LA, LB, LC, RA, RB, RC} = lamps_q;
   assign BUSY  = busy_q;
   assign STATE = state_out_q;

endmodule
